// File: rtl/mastermind_board_store.sv
// Board history store for the Mastermind display path.
// Receives guess/score/game-count/master strobes from the game engine, keeps one row per
// scored round, and serves rows to the VGA renderer through a registered read port.
module mastermind_board_store #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned GUESS_W = 12,
  parameter int unsigned SCORE_W = 4,
  localparam int unsigned AW     = $clog2(ROWS)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [3:0]         numGames,
  input  logic               loadNumGames,
  input  logic [GUESS_W-1:0] guess,
  input  logic               loadGuess,
  input  logic [SCORE_W-1:0] znarly,
  input  logic [SCORE_W-1:0] zood,
  input  logic               loadZnarlyZood,
  input  logic               clearGame,
  input  logic [GUESS_W-1:0] masterPattern,
  input  logic               displayMaster,
  input  logic [AW-1:0]      rd_addr,
  output logic [GUESS_W-1:0] rd_guess,
  output logic [SCORE_W-1:0] rd_znarly,
  output logic [SCORE_W-1:0] rd_zood,
  output logic               rd_valid,
  output logic [3:0]         games_out,
  output logic [AW:0]        rows_used,
  output logic [GUESS_W-1:0] pending_guess,
  output logic               pending_valid,
  output logic [GUESS_W-1:0] master_out,
  output logic               master_show,
  output logic               board_full,
  output logic               proto_err
);

  localparam logic [0:0] StIdle      = 1'b0;
  localparam logic [0:0] StHaveGuess = 1'b1;

  localparam logic [AW:0] RowsW = (AW+1)'(ROWS);

  logic [0:0]         state_q, state_d;
  logic [AW:0]        rows_q, rows_d;
  logic [GUESS_W-1:0] pend_q, pend_d;
  logic               err_q, err_d;
  logic               wr_en, clr_rows, full;
  logic [AW-1:0]      widx;

  logic [ROWS-1:0]    row_valid_q;
  logic [GUESS_W-1:0] row_guess_q  [ROWS];
  logic [SCORE_W-1:0] row_znarly_q [ROWS];
  logic [SCORE_W-1:0] row_zood_q   [ROWS];

  logic [GUESS_W-1:0] rd_guess_q;
  logic [SCORE_W-1:0] rd_znarly_q, rd_zood_q;
  logic               rd_valid_q;
  logic [3:0]         games_q;
  logic [GUESS_W-1:0] master_q;
  logic               show_q;

  // Rows are filled strictly in order, so the scored-row count doubles as the write pointer.
  assign full = (rows_q == RowsW);
  assign widx = rows_q[AW-1:0];

  // Protocol FSM: clear wins, then the score commits the old guess before a new one latches.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    pend_d   = pend_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    clr_rows = 1'b0;
    if (clearGame) begin
      state_d  = StIdle;
      rows_d   = '0;
      err_d    = 1'b0;
      clr_rows = 1'b1;
    end else begin
      if (loadZnarlyZood) begin
        if (state_q == StIdle) begin
          err_d = 1'b1;
        end else begin
          state_d = StIdle;
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            rows_d = rows_q + 1'b1;
          end
        end
      end
      if (loadGuess) begin
        // A second guess without a score in between loses the first one.
        if (state_q == StHaveGuess && !loadZnarlyZood) err_d = 1'b1;
        pend_d  = guess;
        state_d = StHaveGuess;
      end
    end
  end

  // FSM and counter state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rows_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // Board row storage; clear only drops valid bits, stale data is masked by them.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      row_valid_q <= '0;
      for (int i = 0; i < int'(ROWS); i++) begin
        row_guess_q[i]  <= '0;
        row_znarly_q[i] <= '0;
        row_zood_q[i]   <= '0;
      end
    end else if (clr_rows) begin
      row_valid_q <= '0;
    end else if (wr_en) begin
      row_valid_q[widx]  <= 1'b1;
      row_guess_q[widx]  <= pend_q;
      row_znarly_q[widx] <= znarly;
      row_zood_q[widx]   <= zood;
    end
  end

  // Registered read port; sees pre-write contents of a row written in the same cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_guess_q  <= '0;
      rd_znarly_q <= '0;
      rd_zood_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else if (32'(rd_addr) < ROWS) begin
      rd_guess_q  <= row_guess_q[rd_addr];
      rd_znarly_q <= row_znarly_q[rd_addr];
      rd_zood_q   <= row_zood_q[rd_addr];
      rd_valid_q  <= row_valid_q[rd_addr];
    end else begin
      rd_guess_q  <= '0;
      rd_znarly_q <= '0;
      rd_zood_q   <= '0;
      rd_valid_q  <= 1'b0;
    end
  end

  // Game count and master pattern registers, independent of the FSM and of clearGame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      games_q  <= '0;
      master_q <= '0;
      show_q   <= 1'b0;
    end else begin
      if (loadNumGames)  games_q  <= numGames;
      if (displayMaster) master_q <= masterPattern;
      show_q <= displayMaster;
    end
  end

  assign rd_guess      = rd_guess_q;
  assign rd_znarly     = rd_znarly_q;
  assign rd_zood       = rd_zood_q;
  assign rd_valid      = rd_valid_q;
  assign games_out     = games_q;
  assign rows_used     = rows_q;
  assign pending_guess = pend_q;
  assign pending_valid = (state_q == StHaveGuess);
  assign master_out    = master_q;
  assign master_show   = show_q;
  assign board_full    = full;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_mastermind_board_store.sv
// Bench for mastermind_board_store: directed scenarios followed by random strobes, all
// checked every cycle against a queue-based model of the board.
module tb_mastermind_board_store;

  localparam int ROWS = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  numGames;
  logic        loadNumGames;
  logic [11:0] guess;
  logic        loadGuess;
  logic [3:0]  znarly, zood;
  logic        loadZnarlyZood;
  logic        clearGame;
  logic [11:0] masterPattern;
  logic        displayMaster;
  logic [2:0]  rd_addr;
  logic [11:0] rd_guess;
  logic [3:0]  rd_znarly, rd_zood;
  logic        rd_valid;
  logic [3:0]  games_out;
  logic [3:0]  rows_used;
  logic [11:0] pending_guess;
  logic        pending_valid;
  logic [11:0] master_out;
  logic        master_show;
  logic        board_full;
  logic        proto_err;

  mastermind_board_store dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .numGames       (numGames),
    .loadNumGames   (loadNumGames),
    .guess          (guess),
    .loadGuess      (loadGuess),
    .znarly         (znarly),
    .zood           (zood),
    .loadZnarlyZood (loadZnarlyZood),
    .clearGame      (clearGame),
    .masterPattern  (masterPattern),
    .displayMaster  (displayMaster),
    .rd_addr        (rd_addr),
    .rd_guess       (rd_guess),
    .rd_znarly      (rd_znarly),
    .rd_zood        (rd_zood),
    .rd_valid       (rd_valid),
    .games_out      (games_out),
    .rows_used      (rows_used),
    .pending_guess  (pending_guess),
    .pending_valid  (pending_valid),
    .master_out     (master_out),
    .master_show    (master_show),
    .board_full     (board_full),
    .proto_err      (proto_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [11:0] g;
    logic [3:0]  z;
    logic [3:0]  d;
  } row_t;

  // Reference model: the board is simply the list of scored rounds so far.
  row_t        board[$];
  logic        m_have;
  logic [11:0] m_pend;
  logic        m_err;
  logic [3:0]  m_games;
  logic [11:0] m_master;
  logic        m_show;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    board.delete();
    m_have   = 1'b0;
    m_pend   = '0;
    m_err    = 1'b0;
    m_games  = '0;
    m_master = '0;
    m_show   = 1'b0;
  endtask

  task automatic model_step();
    logic had;
    had = m_have;
    if (clearGame) begin
      board.delete();
      m_have = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (loadZnarlyZood) begin
        if (!had) m_err = 1'b1;
        else begin
          m_have = 1'b0;
          if (board.size() == ROWS) m_err = 1'b1;
          else board.push_back('{g: m_pend, z: znarly, d: zood});
        end
      end
      if (loadGuess) begin
        if (had && !loadZnarlyZood) m_err = 1'b1;
        m_pend = guess;
        m_have = 1'b1;
      end
    end
    if (loadNumGames)  m_games  = numGames;
    if (displayMaster) m_master = masterPattern;
    m_show = displayMaster;
  endtask

  task automatic clear_strobes();
    loadGuess      = 1'b0;
    loadZnarlyZood = 1'b0;
    clearGame      = 1'b0;
    loadNumGames   = 1'b0;
  endtask

  // One clock: predict, advance, compare every output.
  task automatic cycle();
    row_t r;
    logic ev;
    int   a;
    a  = int'(rd_addr);
    ev = (a < board.size());
    r  = ev ? board[a] : '0;
    model_step();
    @(posedge CLOCK_50);
    #1;
    chk("rows_used", 32'(rows_used), 32'(board.size()));
    chk("board_full", 32'(board_full), 32'(board.size() == ROWS));
    chk("pending_valid", 32'(pending_valid), 32'(m_have));
    if (m_have) chk("pending_guess", 32'(pending_guess), 32'(m_pend));
    chk("proto_err", 32'(proto_err), 32'(m_err));
    chk("games_out", 32'(games_out), 32'(m_games));
    chk("master_out", 32'(master_out), 32'(m_master));
    chk("master_show", 32'(master_show), 32'(m_show));
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      chk("rd_guess", 32'(rd_guess), 32'(r.g));
      chk("rd_znarly", 32'(rd_znarly), 32'(r.z));
      chk("rd_zood", 32'(rd_zood), 32'(r.d));
    end
    clear_strobes();
  endtask

  initial begin
    reset          = 1'b1;
    numGames       = '0;
    guess          = '0;
    znarly         = '0;
    zood           = '0;
    masterPattern  = '0;
    displayMaster  = 1'b0;
    rd_addr        = '0;
    clear_strobes();
    model_reset();

    // Reset state
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_rd_guess", 32'(rd_guess), 0);
    chk("rst_rd_znarly", 32'(rd_znarly), 0);
    chk("rst_rd_zood", 32'(rd_zood), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rows_used", 32'(rows_used), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    chk("rst_pending_valid", 32'(pending_valid), 0);
    reset = 1'b0;
    cycle();

    // Single guess and score, then read row 0
    guess = 12'h123; loadGuess = 1'b1;
    cycle();
    cycle();
    cycle();
    znarly = 4'd2; zood = 4'd1; loadZnarlyZood = 1'b1;
    cycle();
    chk("one_rows_used", 32'(rows_used), 1);
    rd_addr = 3'd0;
    cycle();
    chk("one_rd_guess", 32'(rd_guess), 32'h123);
    chk("one_rd_znarly", 32'(rd_znarly), 2);
    chk("one_rd_zood", 32'(rd_zood), 1);
    chk("one_rd_valid", 32'(rd_valid), 1);

    // Fill past the end: nine pairs on a fresh board
    clearGame = 1'b1;
    cycle();
    for (int i = 0; i < 9; i++) begin
      guess = 12'($urandom); loadGuess = 1'b1;
      cycle();
      znarly = 4'($urandom); zood = 4'($urandom); loadZnarlyZood = 1'b1;
      cycle();
    end
    chk("full_rows_used", 32'(rows_used), 8);
    chk("full_board_full", 32'(board_full), 1);
    chk("full_proto_err", 32'(proto_err), 1);
    for (int a = 0; a < ROWS; a++) begin
      rd_addr = 3'(a);
      cycle();
    end

    // Clear in the same cycle as a score
    guess = 12'h5A5; loadGuess = 1'b1;
    cycle();
    clearGame = 1'b1; znarly = 4'd3; zood = 4'd1; loadZnarlyZood = 1'b1;
    cycle();
    chk("clr_rows_used", 32'(rows_used), 0);
    chk("clr_proto_err", 32'(proto_err), 0);
    chk("clr_pending_valid", 32'(pending_valid), 0);
    for (int a = 0; a < ROWS; a++) begin
      rd_addr = 3'(a);
      cycle();
      chk("clr_rd_valid", 32'(rd_valid), 0);
    end

    // Score with no guess pending
    znarly = 4'd1; zood = 4'd1; loadZnarlyZood = 1'b1;
    cycle();
    chk("orphan_rows_used", 32'(rows_used), 0);
    chk("orphan_proto_err", 32'(proto_err), 1);

    // Master pattern latches only while displayMaster is high
    displayMaster = 1'b1; masterPattern = 12'hABC;
    cycle();
    displayMaster = 1'b0; masterPattern = 12'h321;
    cycle();
    cycle();
    chk("master_hold", 32'(master_out), 32'hABC);
    chk("master_show_low", 32'(master_show), 0);

    // Random strobes against the model
    for (int n = 0; n < 3000; n++) begin
      guess          = 12'($urandom);
      znarly         = 4'($urandom);
      zood           = 4'($urandom);
      numGames       = 4'($urandom);
      masterPattern  = 12'($urandom);
      rd_addr        = 3'($urandom_range(0, 7));
      loadGuess      = ($urandom_range(0, 2) == 0);
      loadZnarlyZood = ($urandom_range(0, 2) == 0);
      clearGame      = ($urandom_range(0, 39) == 0);
      loadNumGames   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) displayMaster = ~displayMaster;
      cycle();
    end

    // Asynchronous reset while a guess is pending
    clearGame = 1'b1;
    cycle();
    guess = 12'h777; loadGuess = 1'b1;
    cycle();
    chk("pre_arst_pending", 32'(pending_valid), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_pending_valid", 32'(pending_valid), 0);
    chk("arst_rows_used", 32'(rows_used), 0);
    chk("arst_master_out", 32'(master_out), 0);
    #4;
    reset = 1'b0;
    model_reset();
    displayMaster = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
